multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode and sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, and produces the 2-bit `ALUOp` consumed by the ALU control decoder. It also handles a ready handshake to instruction/data memory.

## Interface

Parameters:
- `OP_RTYPE`, 6'b000000, R-type opcode
- `OP_LW`, 6'b100011, load word
- `OP_SW`, 6'b101011, store word
- `OP_BEQ`, 6'b000100, branch on equal
- `OP_J`, 6'b000010, jump
- `OP_ADDI`, 6'b001000, add immediate

Ports:
- `clk`  in  1  clock, all state changes on the rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `opcode`  in  6  instruction register bits [31:26], sampled in DECODE
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  datapath controls
- `ALUSrcB`  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `ALUOp`  out  2  00 = add, 01 = subtract, 10 = decode funct field
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction
- `illegal_op`  out  1  one-cycle pulse when an unsupported opcode is decoded
- `state`  out  4  current state, for debug

## Operation

States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12–15 are unused; they go to FETCH on the next edge with all outputs at 0.

Outputs are a function of state, except where gated by `mem_ready`. Any output not listed for a state is 0.

- **FETCH:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - LW or SW → MEMADR
  - RTYPE → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDIEX
  - any other opcode → FETCH, with `illegal_op`=1 and `instr_done`=1
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for LW, MEMWR for SW. The opcode is re-read here; the IR is stable.
- **MEMRD:** MemRead=1, IorD=1. Waits for `mem_ready`, then goes to MEMWB.
- **MEMWB:** RegDst=0, MemtoReg=1, RegWrite=1, `instr_done`=1. Goes to FETCH.
- **MEMWR:** MemWrite=1, IorD=1. Waits for `mem_ready`. `instr_done` equals `mem_ready`. Goes to FETCH.
- **EXEC:** ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- **ALUWB:** RegDst=1, MemtoReg=0, RegWrite=1, `instr_done`=1. Goes to FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, `instr_done`=1. Goes to FETCH.
- **JUMP:** PCWrite=1, PCSource=10, `instr_done`=1. Goes to FETCH.
- **ADDIEX:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- **ADDIWB:** RegDst=0, MemtoReg=0, RegWrite=1, `instr_done`=1. Goes to FETCH.

Invariants:
- MemRead and MemWrite are never high in the same cycle.
- RegWrite, MemWrite, PCWrite and IRWrite are never high in DECODE.

## Timing

- **Reset:** on a rising edge with `rst_n`=0, state becomes FETCH. While `rst_n`=0, all outputs are forced to 0 combinationally; `state` reads 0. The first fetch begins in the cycle after `rst_n` rises.
- **Reset mid-instruction:** aborts the instruction with no further writes. A pending memory access is dropped; `MemRead`/`MemWrite` go low in the same cycle.
- **Latency, with `mem_ready` tied to 1:**
  - R-type: 4 cycles
  - ADDI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ: 3 cycles
  - J: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle that `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
- `mem_ready` high in the same cycle the state is entered completes the access in that cycle; there is no minimum wait.
- `instr_done` is high for exactly one cycle per instruction, including illegal opcodes. `illegal_op` is high only in the DECODE cycle that rejects the opcode.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles with `mem_ready`=1 → all outputs 0, `state`=0. Release → the next cycle shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- **R-type:** `opcode`=000000, `mem_ready`=1 → state sequence 0,1,6,7,0. EXEC shows ALUOp=10. ALUWB shows RegWrite=1, RegDst=1, `instr_done`=1.
- **LW with stalls:** `opcode`=100011, `mem_ready` low for 2 cycles in FETCH and 3 in MEMRD → sequence 0,0,0,1,2,3,3,3,3,4. IRWrite is high only in the 3rd FETCH cycle. MEMWB shows MemtoReg=1.
- **SW, then BEQ, then J, back to back:** SW stays in MEMWR until `mem_ready`, and `instr_done` coincides with `mem_ready`. BEQ shows ALUOp=01, PCWriteCond=1, PCSource=01. J shows PCWrite=1, PCSource=10.
- **Illegal opcode:** `opcode`=111111 → DECODE pulses `illegal_op`=1 and `instr_done`=1, then FETCH. No RegWrite, MemWrite or PCWriteCond at any point.
- **Reset mid-operation:** drop `rst_n` during MEMRD with `mem_ready`=0 → MemRead goes to 0 in the same cycle and state=0 after the edge. No RegWrite occurs.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath/memory.
// master is the controller side; slave is the datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
           RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
           RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode, execute,
// memory and writeback, driving every datapath control, with a memory ready handshake.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input logic                        clk,
  input logic                        rst_n,
  multicycle_control_if.master       ctrl
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = StFetch;
    ctrl.PCWrite     = 1'b0;
    ctrl.PCWriteCond = 1'b0;
    ctrl.IorD        = 1'b0;
    ctrl.MemRead     = 1'b0;
    ctrl.MemWrite    = 1'b0;
    ctrl.MemtoReg    = 1'b0;
    ctrl.IRWrite     = 1'b0;
    ctrl.RegWrite    = 1'b0;
    ctrl.RegDst      = 1'b0;
    ctrl.ALUSrcA     = 1'b0;
    ctrl.ALUSrcB     = 2'b00;
    ctrl.PCSource    = 2'b00;
    ctrl.ALUOp       = 2'b00;
    ctrl.instr_done  = 1'b0;
    ctrl.illegal_op  = 1'b0;

    // Reset forces every output low combinationally, dropping any pending access.
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          ctrl.MemRead = 1'b1;
          ctrl.ALUSrcB = 2'b01;
          ctrl.IRWrite = ctrl.mem_ready;
          ctrl.PCWrite = ctrl.mem_ready;
          state_d      = ctrl.mem_ready ? StDecode : StFetch;
        end
        StDecode: begin
          ctrl.ALUSrcB = 2'b11;
          if (ctrl.opcode == OP_LW || ctrl.opcode == OP_SW) begin
            state_d = StMemAdr;
          end else if (ctrl.opcode == OP_RTYPE) begin
            state_d = StExec;
          end else if (ctrl.opcode == OP_BEQ) begin
            state_d = StBranch;
          end else if (ctrl.opcode == OP_J) begin
            state_d = StJump;
          end else if (ctrl.opcode == OP_ADDI) begin
            state_d = StAddiEx;
          end else begin
            ctrl.illegal_op = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = StFetch;
          end
        end
        StMemAdr: begin
          ctrl.ALUSrcA = 1'b1;
          ctrl.ALUSrcB = 2'b10;
          state_d      = (ctrl.opcode == OP_SW) ? StMemWr : StMemRd;
        end
        StMemRd: begin
          ctrl.MemRead = 1'b1;
          ctrl.IorD    = 1'b1;
          state_d      = ctrl.mem_ready ? StMemWb : StMemRd;
        end
        StMemWb: begin
          ctrl.MemtoReg   = 1'b1;
          ctrl.RegWrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        StMemWr: begin
          ctrl.MemWrite   = 1'b1;
          ctrl.IorD       = 1'b1;
          ctrl.instr_done = ctrl.mem_ready;
          state_d         = ctrl.mem_ready ? StFetch : StMemWr;
        end
        StExec: begin
          ctrl.ALUSrcA = 1'b1;
          ctrl.ALUOp   = 2'b10;
          state_d      = StAluWb;
        end
        StAluWb: begin
          ctrl.RegDst     = 1'b1;
          ctrl.RegWrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        StBranch: begin
          ctrl.ALUSrcA     = 1'b1;
          ctrl.ALUOp       = 2'b01;
          ctrl.PCWriteCond = 1'b1;
          ctrl.PCSource    = 2'b01;
          ctrl.instr_done  = 1'b1;
        end
        StJump: begin
          ctrl.PCWrite    = 1'b1;
          ctrl.PCSource   = 2'b10;
          ctrl.instr_done = 1'b1;
        end
        StAddiEx: begin
          ctrl.ALUSrcA = 1'b1;
          ctrl.ALUSrcB = 2'b10;
          state_d      = StAddiWb;
        end
        StAddiWb: begin
          ctrl.RegWrite   = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  assign ctrl.state = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle state and full control
// vector checked against hand-written expectations.
module tb_multicycle_control;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  multicycle_control_if ifc ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite RegWrite RegDst
  //              ALUSrcA ALUSrcB PCSource ALUOp instr_done illegal_op
  localparam logic [17:0] VFetchR = 18'b1_0_0_1_0_0_1_0_0_0_01_00_00_0_0;
  localparam logic [17:0] VFetchS = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] VDec    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] VDecIll = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
  localparam logic [17:0] VMemAdr = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] VMemRd  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] VMemWb  = 18'b0_0_0_0_0_1_0_1_0_0_00_00_00_1_0;
  localparam logic [17:0] VMemWrS = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] VMemWrR = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] VExec   = 18'b0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
  localparam logic [17:0] VAluWb  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] VBranch = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] VJump   = 18'b1_0_0_0_0_0_0_0_0_0_00_10_00_1_0;
  localparam logic [17:0] VAddiEx = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] VAddiWb = 18'b0_0_0_0_0_0_0_1_0_0_00_00_00_1_0;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpJ = 6'b000010, OpAddi = 6'b001000;
  localparam logic [5:0] OpBad = 6'b111111;

  function automatic logic [17:0] ctl_vec();
    return {ifc.PCWrite, ifc.PCWriteCond, ifc.IorD, ifc.MemRead, ifc.MemWrite, ifc.MemtoReg,
            ifc.IRWrite, ifc.RegWrite, ifc.RegDst, ifc.ALUSrcA, ifc.ALUSrcB, ifc.PCSource,
            ifc.ALUOp, ifc.instr_done, ifc.illegal_op};
  endfunction

  // Apply one reset cycle and release it; returns at the start of the first FETCH cycle.
  task automatic restart();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    ifc.mem_ready = 1'b1;
    ifc.opcode    = OpR;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (ctl_vec() !== 18'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, ctl_vec(), 18'd0);
      end
      n_checks++;
      if (ifc.state !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: got %0d expected 0", i, ifc.state);
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ctl_vec() !== VFetchR) begin
      n_fail++;
      $display("FAIL reset_release_fetch: got %b expected %b", ctl_vec(), VFetchR);
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  ops [5] = '{OpR, OpR, OpR, OpR, OpR};
    logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  st  [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [17:0] vec [5] = '{VFetchR, VDec, VExec, VAluWb, VFetchR};
    restart();
    for (int i = 0; i < 5; i++) begin
      ifc.opcode = ops[i]; ifc.mem_ready = rdy[i];
      #1;
      n_checks++;
      if (ifc.state !== st[i]) begin
        n_fail++;
        $display("FAIL rtype_state step %0d: got %0d expected %0d", i, ifc.state, st[i]);
      end
      n_checks++;
      if (ctl_vec() !== vec[i]) begin
        n_fail++;
        $display("FAIL rtype_ctl step %0d: got %b expected %b", i, ctl_vec(), vec[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lw_stalls();
    logic [5:0]  ops [10] = '{OpLw, OpLw, OpLw, OpLw, OpLw, OpLw, OpLw, OpLw, OpLw, OpLw};
    logic        rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  st  [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    logic [17:0] vec [10] = '{VFetchS, VFetchS, VFetchR, VDec, VMemAdr,
                              VMemRd, VMemRd, VMemRd, VMemRd, VMemWb};
    restart();
    for (int i = 0; i < 10; i++) begin
      ifc.opcode = ops[i]; ifc.mem_ready = rdy[i];
      #1;
      n_checks++;
      if (ifc.state !== st[i]) begin
        n_fail++;
        $display("FAIL lw_state step %0d: got %0d expected %0d", i, ifc.state, st[i]);
      end
      n_checks++;
      if (ctl_vec() !== vec[i]) begin
        n_fail++;
        $display("FAIL lw_ctl step %0d: got %b expected %b", i, ctl_vec(), vec[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [13] = '{OpSw, OpSw, OpSw, OpSw, OpSw, OpSw, OpBeq, OpBeq, OpBeq,
                              OpJ, OpJ, OpJ, OpJ};
    logic        rdy [13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  st  [13] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd0, 4'd1, 4'd8,
                              4'd0, 4'd1, 4'd9, 4'd0};
    logic [17:0] vec [13] = '{VFetchR, VDec, VMemAdr, VMemWrS, VMemWrS, VMemWrR,
                              VFetchR, VDec, VBranch, VFetchR, VDec, VJump, VFetchR};
    restart();
    for (int i = 0; i < 13; i++) begin
      ifc.opcode = ops[i]; ifc.mem_ready = rdy[i];
      #1;
      n_checks++;
      if (ifc.state !== st[i]) begin
        n_fail++;
        $display("FAIL b2b_state step %0d: got %0d expected %0d", i, ifc.state, st[i]);
      end
      n_checks++;
      if (ctl_vec() !== vec[i]) begin
        n_fail++;
        $display("FAIL b2b_ctl step %0d: got %b expected %b", i, ctl_vec(), vec[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ADDI with mem_ready low outside FETCH, which must be ignored; then an illegal opcode.
  task automatic test_addi_illegal();
    logic [5:0]  ops [8] = '{OpAddi, OpAddi, OpAddi, OpAddi, OpBad, OpBad, OpBad, OpBad};
    logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  st  [8] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd1, 4'd0, 4'd0};
    logic [17:0] vec [8] = '{VFetchR, VDec, VAddiEx, VAddiWb, VFetchR, VDecIll,
                             VFetchS, VFetchS};
    restart();
    for (int i = 0; i < 8; i++) begin
      ifc.opcode = ops[i]; ifc.mem_ready = rdy[i];
      #1;
      n_checks++;
      if (ifc.state !== st[i]) begin
        n_fail++;
        $display("FAIL addi_ill_state step %0d: got %0d expected %0d", i, ifc.state, st[i]);
      end
      n_checks++;
      if (ctl_vec() !== vec[i]) begin
        n_fail++;
        $display("FAIL addi_ill_ctl step %0d: got %b expected %b", i, ctl_vec(), vec[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    restart();
    ifc.opcode    = OpLw;
    ifc.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ifc.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (ifc.state !== 4'd3 || ifc.MemRead !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_in_memrd: got state %0d MemRead %b expected 3 1",
               ifc.state, ifc.MemRead);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ctl_vec() !== 18'd0 || ifc.state !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_same_cycle: got %b state %0d expected 0 0", ctl_vec(), ifc.state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ifc.state !== 4'd0 || ctl_vec() !== VFetchS) begin
      n_fail++;
      $display("FAIL midrst_after_edge: got state %0d ctl %b expected 0 %b",
               ifc.state, ctl_vec(), VFetchS);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    ifc.opcode    = OpR;
    ifc.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stalls();
    test_back_to_back();
    test_addi_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
